// File: rtl/read_keyboard_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad scanner.
// Contents:
//   NUM_ROWS / NUM_COLS / NUM_KEYS : keypad geometry (row*NUM_COLS + col indexing)
//   ROW_W / KEY_W                  : widths of a row select and a key index
//   scan_state_t                   : row sequencer run state
//   onehot_to_index()              : binary index of a one-hot key vector (0 for all-zero)
//   is_onehot()                    : true when exactly one bit is set
package read_keyboard_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int unsigned ROW_W    = $clog2(NUM_ROWS);
    localparam int unsigned KEY_W    = $clog2(NUM_KEYS);

    typedef logic [NUM_KEYS-1:0] key_vec_t;
    typedef logic [KEY_W-1:0]    key_idx_t;

    typedef enum logic {
        SCAN_IDLE = 1'b0,
        SCAN_RUN  = 1'b1
    } scan_state_t;

    // OR of the indices of all set bits; exact for one-hot input, 0 for all-zero input.
    function automatic key_idx_t onehot_to_index(input key_vec_t vec);
        key_idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (vec[i]) begin
                idx = idx | key_idx_t'(i);
            end
        end
        return idx;
    endfunction

    // Nonzero with no second set bit: clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot(input key_vec_t vec);
        return (vec != '0) && ((vec & (vec - key_vec_t'(1))) == '0);
    endfunction

endpackage : read_keyboard_pkg

// File: rtl/row_scan_tick.sv
// Row dwell counter and row sequencer for the keypad scanner.
// Each row is selected for SCAN_CYCLES cycles in order 0,1,2,3,0,...; sample_pulse
// marks the last cycle of every dwell.
// Ports:
//   clk_i          : system clock, rising edge
//   rst_i          : synchronous active-high reset
//   row_sel_o      : currently selected row (registered)
//   sample_pulse_o : high on the last cycle of each row dwell (registered)
//   scan_active_o  : high while scanning; low during reset and the first reset-exit cycle
module row_scan_tick
    import read_keyboard_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES = 5000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [ROW_W-1:0] row_sel_o,
    output logic             sample_pulse_o,
    output logic             scan_active_o
);

    localparam int unsigned         DWELL_W    = $clog2(SCAN_CYCLES);
    localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);

    scan_state_t         state_q, state_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [ROW_W-1:0]    row_q,   row_d;
    logic                pulse_q, pulse_d;
    logic                active_q, active_d;

    // Next-state: IDLE holds for one cycle after reset so row 0 then gets a full dwell.
    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        row_d    = row_q;
        pulse_d  = 1'b0;
        active_d = active_q;

        case (state_q)
            SCAN_IDLE: begin
                state_d  = SCAN_RUN;
                dwell_d  = '0;
                row_d    = '0;
                active_d = 1'b1;
            end
            SCAN_RUN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    // NUM_ROWS is a power of two, so the row index wraps naturally.
                    row_d   = row_q + 1'b1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
                pulse_d = (dwell_d == DWELL_LAST);
            end
            default: begin
                state_d  = SCAN_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= SCAN_IDLE;
            dwell_q  <= '0;
            row_q    <= '0;
            pulse_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            row_q    <= row_d;
            pulse_q  <= pulse_d;
            active_q <= active_d;
        end
    end

    assign row_sel_o      = row_q;
    assign sample_pulse_o = pulse_q;
    assign scan_active_o  = active_q;

endmodule : row_scan_tick

// File: rtl/read_keyboard.sv
// 4x4 matrix keypad scanner with ghost rejection and optional frame debounce.
// Rows are driven low one at a time; synchronized active-low columns are sampled at the
// end of each row dwell and assembled into a 16-bit frame. Frames with more than one
// pressed key read as no key.
// Build option: define READ_KEYBOARD_DEBOUNCE_EN to require DEBOUNCE_FRAMES identical
// consecutive frames before pad changes; otherwise pad follows every completed frame.
// Ports:
//   CLOCK_50   : system clock, rising edge
//   reset      : synchronous active-high reset
//   cols       : column lines, active-low, externally pulled up
//   rows       : row lines, active row driven 0, others high-Z
//   pad        : one-hot pressed key (bit = row*4 + col), 0 for none/invalid
//   key_code   : binary index of the pad bit, 0 when pad is 0
//   key_strobe : one-cycle pulse when pad changes to a nonzero value
module read_keyboard
    import read_keyboard_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 5000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] cols,
    inout  wire  [NUM_ROWS-1:0] rows,
    output logic [NUM_KEYS-1:0] pad,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_strobe
);

    // Elaboration-time parameter sanity.
    if (SCAN_CYCLES < 4) begin : g_bad_scan_cycles
        $error("read_keyboard: SCAN_CYCLES must be at least 4");
    end
    if (DEBOUNCE_FRAMES < 1) begin : g_bad_debounce_frames
        $error("read_keyboard: DEBOUNCE_FRAMES must be at least 1");
    end

    logic [ROW_W-1:0]    row_sel;
    logic                sample_pulse;
    logic                scan_active;

    logic [NUM_COLS-1:0] cols_meta_q, cols_sync_q;
    key_vec_t            frame_q, frame_d;
    key_vec_t            frame_asm_c;
    key_vec_t            frame_val_c;
    logic                frame_done_c;

    logic                accept_c;
    key_vec_t            accept_val_c;

    key_vec_t            pad_q,    pad_d;
    key_idx_t            code_q,   code_d;
    logic                strobe_q, strobe_d;

    row_scan_tick #(
        .SCAN_CYCLES (SCAN_CYCLES)
    ) u_row_scan_tick (
        .clk_i          (CLOCK_50),
        .rst_i          (reset),
        .row_sel_o      (row_sel),
        .sample_pulse_o (sample_pulse),
        .scan_active_o  (scan_active)
    );

    // Row drivers: only the selected row is pulled low, never during reset.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row_drv
        assign rows[r] = (scan_active && (row_sel == ROW_W'(r))) ? 1'b0 : 1'bz;
    end

    // Two-flop column synchronizer; resets to the released (all-high) level.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cols_meta_q <= '1;
            cols_sync_q <= '1;
        end else begin
            cols_meta_q <= cols;
            cols_sync_q <= cols_meta_q;
        end
    end

    // Frame assembly: current row's pressed columns merged into the partial frame.
    always_comb begin
        frame_asm_c = frame_q;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (row_sel == ROW_W'(r)) begin
                frame_asm_c[r*NUM_COLS +: NUM_COLS] = ~cols_sync_q;
            end
        end
    end

    assign frame_done_c = sample_pulse && (row_sel == ROW_W'(NUM_ROWS - 1));
    assign frame_val_c  = is_onehot(frame_asm_c) ? frame_asm_c : '0;

    // Partial-frame register; emptied after each completed frame.
    always_comb begin
        frame_d = frame_q;
        if (frame_done_c) begin
            frame_d = '0;
        end else if (sample_pulse) begin
            frame_d = frame_asm_c;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

`ifdef READ_KEYBOARD_DEBOUNCE_EN
    localparam int unsigned     DB_W      = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE_FRAMES);

    key_vec_t        cand_q,   cand_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Candidate tracking: a matching frame counts up (saturating), a differing one restarts at 1.
    always_comb begin
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        accept_c = 1'b0;
        if (frame_done_c) begin
            if (frame_val_c == cand_q) begin
                if (db_cnt_q != DB_TARGET) begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end else begin
                cand_d   = frame_val_c;
                db_cnt_d = DB_W'(1);
            end
            accept_c = (db_cnt_d == DB_TARGET);
        end
    end

    assign accept_val_c = cand_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cand_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            cand_q   <= cand_d;
            db_cnt_q <= db_cnt_d;
        end
    end
`else
    assign accept_c     = frame_done_c;
    assign accept_val_c = frame_val_c;
`endif

    // Output update; re-accepting the current value does not strobe.
    always_comb begin
        pad_d    = pad_q;
        strobe_d = 1'b0;
        if (accept_c) begin
            pad_d    = accept_val_c;
            strobe_d = (accept_val_c != pad_q) && (accept_val_c != '0);
        end
        code_d = onehot_to_index(pad_d);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pad_q    <= '0;
            code_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            pad_q    <= pad_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
        end
    end

    assign pad        = pad_q;
    assign key_code   = code_q;
    assign key_strobe = strobe_q;

endmodule : read_keyboard

// File: tb/tb_read_keyboard.sv
// Bench for read_keyboard with SCAN_CYCLES=4 (16-cycle frames) and DEBOUNCE_FRAMES=2.
// A keypad model closes row/column contacts for the keys in 'keys'. Stimulus pushes the
// expected output events (pad change or strobe) with their cycle; a monitor pops and
// compares each event the DUT presents. Expectations follow READ_KEYBOARD_DEBOUNCE_EN.
module tb_read_keyboard;

    logic        CLOCK_50;
    logic        reset;
    logic [3:0]  cols;
    wire  [3:0]  rows;
    logic [15:0] pad;
    logic [3:0]  key_code;
    logic        key_strobe;

    logic [15:0] keys;
    int          cyc;
    int          base;
    int          checks;
    int          errors;
    logic        mon_en;
    logic [15:0] prev_pad;

    typedef struct {
        logic [15:0] pad;
        logic [3:0]  code;
        logic        strobe;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];

    read_keyboard #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .cols       (cols),
        .rows       (rows),
        .pad        (pad),
        .key_code   (key_code),
        .key_strobe (key_strobe)
    );

    for (genvar i = 0; i < 4; i++) begin : g_pu
        pullup (rows[i]);
    end

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Keypad: a pressed key connects its row to its column.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (rows[r] == 1'b0)) begin
                    cols[c] = 1'b0;
                end
            end
        end
    end

    always @(posedge CLOCK_50) begin
        if (cyc > 3000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 3000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    // Monitor: any pad change or strobe is an event and must match the queue head.
    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            if ((pad !== prev_pad) || (key_strobe === 1'b1)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cyc=%0d pad=%h code=%0d strobe=%b, required no event",
                             cyc - base, pad, key_code, key_strobe);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if ((pad !== e.pad) || (key_code !== e.code) ||
                        (key_strobe !== e.strobe) || (cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d pad=%h code=%0d strobe=%b, required cyc=%0d pad=%h code=%0d strobe=%b",
                                 cyc - base, pad, key_code, key_strobe,
                                 e.cyc - base, e.pad, e.code, e.strobe);
                    end
                end
            end
            prev_pad = pad;
        end
    end

    function automatic void push(input int t, input logic [15:0] p, input logic [3:0] c,
                                 input logic s);
        ev_t e;
        e.pad    = p;
        e.code   = c;
        e.strobe = s;
        e.cyc    = base + t;
        exp_q.push_back(e);
    endfunction

    task automatic wait_until(input int t);
        while (cyc < base + t) @(negedge CLOCK_50);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        mon_en   = 1'b0;
        prev_pad = 16'h0;
        keys     = 16'h0;
        base     = 0;
        reset    = 1'b1;

        // Reset state.
        repeat (3) @(negedge CLOCK_50);
        chk("reset_pad",    32'(pad),        32'h0);
        chk("reset_code",   32'(key_code),   32'h0);
        chk("reset_strobe", 32'(key_strobe), 32'h0);
        chk("reset_rows",   32'(rows),       32'hF);

        reset  = 1'b0;
        base   = cyc + 1;
        mon_en = 1'b1;

`ifdef READ_KEYBOARD_DEBOUNCE_EN
        push(192, 16'h0040, 4'd6, 1'b1);
        push(256, 16'h0000, 4'd0, 1'b0);
        push(384, 16'h0008, 4'd3, 1'b1);
        push(448, 16'h0200, 4'd9, 1'b1);
        push(490, 16'h0000, 4'd0, 1'b0);
`else
        push(176, 16'h0040, 4'd6, 1'b1);
        push(240, 16'h0000, 4'd0, 1'b0);
        push(336, 16'h0008, 4'd3, 1'b1);
        push(352, 16'h0000, 4'd0, 1'b0);
        push(368, 16'h0008, 4'd3, 1'b1);
        push(432, 16'h0200, 4'd9, 1'b1);
        push(490, 16'h0000, 4'd0, 1'b0);
`endif

        // Idle rotation: one row low, four cycles per row.
        for (int t = 0; t < 32; t++) begin
            logic [3:0] req;
            wait_until(t);
            req = 4'hF & ~(4'b0001 << ((t / 4) % 4));
            chk("idle_rows", 32'(rows), 32'(req));
        end

        wait_until(160);  keys = 16'h0040;   // key 6 (row1/col2)
        wait_until(224);  keys = 16'h0000;   // release
        wait_until(256);  keys = 16'h0021;   // keys 0 and 5 together
        wait_until(320);  keys = 16'h0008;   // key 3 bounce: present
        wait_until(336);  keys = 16'h0000;   //   absent
        wait_until(352);  keys = 16'h0008;   //   stable
        wait_until(416);  keys = 16'h0200;   // direct change to key 9

        // Reset during the row-2 dwell of frame 30.
        wait_until(489);
        chk("pre_reset_rows", 32'(rows), 32'hB);
        reset = 1'b1;
        wait_until(490);
        chk("mid_reset_rows", 32'(rows),     32'hF);
        chk("mid_reset_pad",  32'(pad),      32'h0);
        chk("mid_reset_code", 32'(key_code), 32'h0);
        wait_until(492);
        reset = 1'b0;
        base  = cyc + 1;

`ifdef READ_KEYBOARD_DEBOUNCE_EN
        push(32, 16'h0200, 4'd9,  1'b1);
        push(96, 16'h8000, 4'd15, 1'b1);
`else
        push(16, 16'h0200, 4'd9,  1'b1);
        push(80, 16'h8000, 4'd15, 1'b1);
`endif

        // Scan restarts at row 0 with a full dwell.
        wait_until(0);  chk("restart_rows_t0", 32'(rows), 32'hE);
        wait_until(3);  chk("restart_rows_t3", 32'(rows), 32'hE);
        wait_until(4);  chk("restart_rows_t4", 32'(rows), 32'hD);

        wait_until(64); keys = 16'h8000;     // key 15
        wait_until(160);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d events still pending, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_read_keyboard

// File: doc/read_keyboard.md
READ_KEYBOARD -- requirements
Module: read_keyboard

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 5000, meaning CLOCK_50 cycles each row is driven (100 us at 50 MHz); legal values are 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, meaning the number of consecutive identical full-scan frames needed to accept a new key state; legal values are 1 or more.
REQ-003 SHALL have port CLOCK_50, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port cols, input, 4 bits, keypad column lines; these are active-low with external pull-ups.
REQ-006 SHALL have port rows, inout, 4 bits, keypad row lines; the active row is driven 0 and the others are high-Z.
REQ-007 SHALL have port pad, output, 16 bits, the one-hot pressed key; bit index = row*4 + col; all zeros means no key or an invalid state.
REQ-008 SHALL have port key_code, output, 4 bits, the binary index of the set pad bit; it is 0 when pad is 0.
REQ-009 SHALL have port key_strobe, output, 1 bit, a one-cycle pulse whenever pad changes to a nonzero value.

Function
REQ-010 SHALL pass cols through a 2-flop synchronizer before any use.
REQ-011 SHALL drive row r (r = 0..3) low for exactly SCAN_CYCLES cycles, in the order 0,1,2,3,0,...; exactly one row SHALL be driven at any time.
REQ-012 SHALL sample the synchronized cols on the last cycle of each row dwell; column c reads as pressed when it is 0.
REQ-013 SHALL assemble a 16-bit frame from the four row samples; the frame completes on the row-3 sample.
REQ-014 SHALL treat a frame with zero pressed keys as 0.
REQ-015 SHALL treat a frame with exactly one pressed key as that key's one-hot value.
REQ-016 SHALL treat a frame with two or more pressed keys as 0, i.e. ghost/multi-press is rejected.
REQ-017 SHALL update pad, with debounce enabled, only after DEBOUNCE_FRAMES consecutive frames yield the same value; any differing frame restarts the count with the new value as candidate.
REQ-018 SHALL update pad, key_code and key_strobe in the cycle after the accepting frame completes; key_strobe is high for that one cycle only.
REQ-019 SHALL NOT pulse key_strobe when pad is re-accepted with an unchanged value.
REQ-020 SHALL pulse key_strobe on a direct change from one nonzero key to another nonzero key.
REQ-021 SHALL size the dwell counter as ceil(log2(SCAN_CYCLES)) bits and the debounce counter as ceil(log2(DEBOUNCE_FRAMES+1)) bits; the debounce counter saturates and never wraps.

Reset
REQ-022 SHALL, on reset, set pad=0, key_code=0, key_strobe=0 and all rows to high-Z, and clear the synchronizer, frame, candidate and counters.
REQ-023 SHALL restart scanning at row 0 with a full dwell on the first cycle after reset deasserts.
REQ-024 SHALL discard any partial frame when reset is asserted mid-frame.

Configuration
REQ-025 SHALL, when macro READ_KEYBOARD_DEBOUNCE_EN is defined, implement REQ-017 with the DEBOUNCE_FRAMES filter.
REQ-026 SHALL, when READ_KEYBOARD_DEBOUNCE_EN is undefined, take pad directly from every completed frame with no debounce filter; DEBOUNCE_FRAMES is then ignored.

Structure
REQ-027 SHALL place NUM_ROWS=4, NUM_COLS=4, NUM_KEYS=16 and a onehot-to-index function in package read_keyboard_pkg.
REQ-028 SHALL implement the dwell counter and row sequencer as sub-module row_scan_tick, with outputs row_sel[1:0] and sample_pulse.

Verification (SCAN_CYCLES=4, DEBOUNCE_FRAMES=2, macro defined)
REQ-029 SHALL verify idle behaviour: with no keys pressed for 10 frames, pad stays 0, key_strobe never pulses, and rows show a one-low rotation 4 cycles per row.
REQ-030 SHALL verify a single press: holding key row1/col2 gives pad=16'h0040, key_code=6 and one key_strobe after 2 frames; releasing it gives pad=0 after 2 frames.
REQ-031 SHALL verify multi-press rejection: holding keys 0 and 5 together keeps pad=0 and produces no strobe.
REQ-032 SHALL verify bounce filtering: key 3 present in one frame, absent the next and then stable leaves pad=0 until 2 consecutive matching frames occur, then gives pad=16'h0008.
REQ-033 SHALL verify reset mid-frame: asserting reset during the row-2 dwell gives pad=0 and rows all high-Z on the next cycle, and the scan restarts at row 0.
REQ-034 SHALL verify the macro-off build: a single press of key 15 gives pad=16'h8000 one cycle after the first complete frame.
